// File: rtl/hpdcache_cmo_exec_if.sv
// Signal bundle between a CMO requester, the CMO executor, the cache directory
// and the miss handler. "slave" is the executor's view, "master" the environment's.
interface hpdcache_cmo_exec_if #(
  parameter int unsigned NSETS   = 64,
  parameter int unsigned NLINE_W = 34,
  parameter int unsigned SID_W   = 3,
  parameter int unsigned TID_W   = 6
);
  localparam int unsigned SET_W = $clog2(NSETS);

  // CMO request
  logic               req_valid_i;
  logic               req_ready_o;
  logic [1:0]         req_op_i;
  logic [NLINE_W-1:0] req_nline_i;
  logic [SID_W-1:0]   req_sid_i;
  logic [TID_W-1:0]   req_tid_i;
  logic               req_need_rsp_i;

  // Directory invalidation
  logic               dir_inv_valid_o;
  logic               dir_inv_ready_i;
  logic               dir_inv_all_o;
  logic [SET_W-1:0]   dir_inv_set_o;
  logic [NLINE_W-1:0] dir_inv_nline_o;

  // Prefetch refill
  logic               miss_valid_o;
  logic               miss_ready_i;
  logic [NLINE_W-1:0] miss_nline_o;

  // Completion and status
  logic               rsp_valid_o;
  logic [SID_W-1:0]   rsp_sid_o;
  logic [TID_W-1:0]   rsp_tid_o;
  logic               rsp_error_o;
  logic               busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_nline_i, req_sid_i, req_tid_i, req_need_rsp_i,
    input  dir_inv_ready_i, miss_ready_i,
    output req_ready_o,
    output dir_inv_valid_o, dir_inv_all_o, dir_inv_set_o, dir_inv_nline_o,
    output miss_valid_o, miss_nline_o,
    output rsp_valid_o, rsp_sid_o, rsp_tid_o, rsp_error_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, req_nline_i, req_sid_i, req_tid_i, req_need_rsp_i,
    output dir_inv_ready_i, miss_ready_i,
    input  req_ready_o,
    input  dir_inv_valid_o, dir_inv_all_o, dir_inv_set_o, dir_inv_nline_o,
    input  miss_valid_o, miss_nline_o,
    input  rsp_valid_o, rsp_sid_o, rsp_tid_o, rsp_error_o, busy_o
  );
endinterface

// File: rtl/hpdcache_cmo_exec.sv
// Cache-maintenance operation executor: line/all-set invalidation, prefetch and completion.
// Prefetch issue is compiled in only when HPDCACHE_CMO_PREFETCH_EN is defined.
module hpdcache_cmo_exec #(
  parameter int unsigned NSETS   = 64,
  parameter int unsigned NLINE_W = 34,
  parameter int unsigned SID_W   = 3,
  parameter int unsigned TID_W   = 6
) (
  input logic               clk_i,
  input logic               rst_ni,
  hpdcache_cmo_exec_if.slave cmo
);
  localparam int unsigned            SET_W    = $clog2(NSETS);
  localparam logic [SET_W-1:0]       LAST_SET = SET_W'(NSETS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INV_NLINE,
    ST_INV_ALL,
    ST_PREFETCH,
    ST_RSP
  } state_e;

  typedef enum logic [1:0] {
    OP_INVAL_NLINE = 2'd0,
    OP_INVAL_ALL   = 2'd1,
    OP_PREFETCH    = 2'd2,
    OP_RESERVED    = 2'd3
  } op_e;

  typedef struct packed {
    logic             valid;
    logic [SID_W-1:0] sid;
    logic [TID_W-1:0] tid;
  } rsp_t;

  // A response is only visible when the requester asked for one.
  function automatic rsp_t mk_rsp(input logic             need,
                                  input logic [SID_W-1:0] sid,
                                  input logic [TID_W-1:0] tid);
    rsp_t r;
    r = '0;
    if (need) begin
      r.valid = 1'b1;
      r.sid   = sid;
      r.tid   = tid;
    end
    return r;
  endfunction

  state_e             state_q;
  logic [SID_W-1:0]   sid_q;
  logic [TID_W-1:0]   tid_q;
  logic               need_rsp_q;
  logic               error_q;
  logic [SET_W-1:0]   set_cnt_q;

  logic               req_ready_q;
  logic               dir_valid_q;
  logic               dir_all_q;
  logic [NLINE_W-1:0] dir_nline_q;
  rsp_t               rsp_q;
  logic               busy_q;

`ifdef HPDCACHE_CMO_PREFETCH_EN
  logic               miss_valid_q;
  logic [NLINE_W-1:0] miss_nline_q;
`endif

  // NOTE: every register in this FSM uses non-blocking assignments so all
  // state and outputs update together on the edge, with no ordering races.
  // NOTE: req_ready is a register reset to 0, so it stays low while rst_ni is
  // asserted and rises on the first clock after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      sid_q        <= '0;
      tid_q        <= '0;
      need_rsp_q   <= 1'b0;
      error_q      <= 1'b0;
      set_cnt_q    <= '0;
      req_ready_q  <= 1'b0;
      dir_valid_q  <= 1'b0;
      dir_all_q    <= 1'b0;
      dir_nline_q  <= '0;
      rsp_q        <= '0;
      busy_q       <= 1'b0;
`ifdef HPDCACHE_CMO_PREFETCH_EN
      miss_valid_q <= 1'b0;
      miss_nline_q <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (cmo.req_valid_i) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            sid_q       <= cmo.req_sid_i;
            tid_q       <= cmo.req_tid_i;
            need_rsp_q  <= cmo.req_need_rsp_i;
            set_cnt_q   <= '0;
            unique case (op_e'(cmo.req_op_i))
              OP_INVAL_NLINE: begin
                state_q     <= ST_INV_NLINE;
                dir_valid_q <= 1'b1;
                dir_nline_q <= cmo.req_nline_i;
              end
              OP_INVAL_ALL: begin
                state_q     <= ST_INV_ALL;
                dir_valid_q <= 1'b1;
                dir_all_q   <= 1'b1;
              end
              OP_PREFETCH: begin
`ifdef HPDCACHE_CMO_PREFETCH_EN
                state_q      <= ST_PREFETCH;
                miss_valid_q <= 1'b1;
                miss_nline_q <= cmo.req_nline_i;
`else
                // Without prefetch support the request completes as a no-op.
                state_q <= ST_RSP;
                rsp_q   <= mk_rsp(cmo.req_need_rsp_i, cmo.req_sid_i, cmo.req_tid_i);
`endif
              end
              default: begin
                state_q <= ST_RSP;
                error_q <= 1'b1;
                rsp_q   <= mk_rsp(cmo.req_need_rsp_i, cmo.req_sid_i, cmo.req_tid_i);
              end
            endcase
          end
        end

        ST_INV_NLINE: begin
          if (cmo.dir_inv_ready_i) begin
            state_q     <= ST_RSP;
            dir_valid_q <= 1'b0;
            dir_nline_q <= '0;
            rsp_q       <= mk_rsp(need_rsp_q, sid_q, tid_q);
          end
        end

        ST_INV_ALL: begin
          if (cmo.dir_inv_ready_i) begin
            if (set_cnt_q == LAST_SET) begin
              state_q     <= ST_RSP;
              dir_valid_q <= 1'b0;
              dir_all_q   <= 1'b0;
              set_cnt_q   <= '0;
              rsp_q       <= mk_rsp(need_rsp_q, sid_q, tid_q);
            end else begin
              set_cnt_q <= set_cnt_q + SET_W'(1);
            end
          end
        end

`ifdef HPDCACHE_CMO_PREFETCH_EN
        ST_PREFETCH: begin
          if (cmo.miss_ready_i) begin
            state_q      <= ST_RSP;
            miss_valid_q <= 1'b0;
            miss_nline_q <= '0;
            rsp_q        <= mk_rsp(need_rsp_q, sid_q, tid_q);
          end
        end
`endif

        ST_RSP: begin
          state_q     <= ST_IDLE;
          rsp_q       <= '0;
          error_q     <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmo.req_ready_o     = req_ready_q;
  assign cmo.dir_inv_valid_o = dir_valid_q;
  assign cmo.dir_inv_all_o   = dir_all_q;
  assign cmo.dir_inv_set_o   = set_cnt_q;
  assign cmo.dir_inv_nline_o = dir_nline_q;
  assign cmo.rsp_valid_o     = rsp_q.valid;
  assign cmo.rsp_sid_o       = rsp_q.sid;
  assign cmo.rsp_tid_o       = rsp_q.tid;
  // error_q is only set for the duration of a reserved-op RSP state.
  assign cmo.rsp_error_o     = rsp_q.valid & error_q;
  assign cmo.busy_o          = busy_q;

`ifdef HPDCACHE_CMO_PREFETCH_EN
  assign cmo.miss_valid_o    = miss_valid_q;
  assign cmo.miss_nline_o    = miss_nline_q;
`else
  logic unused_miss_ready;
  assign unused_miss_ready   = cmo.miss_ready_i;
  assign cmo.miss_valid_o    = 1'b0;
  assign cmo.miss_nline_o    = '0;
`endif

endmodule

// File: tb/tb_hpdcache_cmo_exec.sv
// Self-checking bench for hpdcache_cmo_exec: a queue-based transaction model checked
// every cycle, randomized traffic, and directed scenarios with literal expectations.
module tb_hpdcache_cmo_exec;
  localparam int unsigned NSETS   = 64;
  localparam int unsigned NLINE_W = 34;
  localparam int unsigned SID_W   = 3;
  localparam int unsigned TID_W   = 6;
  localparam int unsigned SET_W   = $clog2(NSETS);

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  hpdcache_cmo_exec_if #(.NSETS(NSETS), .NLINE_W(NLINE_W), .SID_W(SID_W), .TID_W(TID_W)) cmo ();

  hpdcache_cmo_exec #(.NSETS(NSETS), .NLINE_W(NLINE_W), .SID_W(SID_W), .TID_W(TID_W)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .cmo   (cmo)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted CMO becomes a queue of issue beats followed by one response cycle.
  localparam logic [1:0] K_LINE = 2'd0, K_ALL = 2'd1, K_MISS = 2'd2;
  typedef struct packed {
    logic [1:0]         kind;
    logic [NLINE_W-1:0] nline;
    logic [SET_W-1:0]   set;
  } item_t;

  item_t            m_q[$];
  bit               m_ready, m_in_rsp, m_need, m_err;
  logic [SID_W-1:0] m_sid;
  logic [TID_W-1:0] m_tid;

  function automatic void model_reset();
    m_q.delete();
    m_ready  = 1'b0;
    m_in_rsp = 1'b0;
    m_need   = 1'b0;
    m_err    = 1'b0;
    m_sid    = '0;
    m_tid    = '0;
  endfunction

  function automatic void model_step();
    item_t it;
    if (m_in_rsp) begin
      m_in_rsp = 1'b0;
      m_ready  = 1'b1;
    end else if (m_q.size() > 0) begin
      if ((m_q[0].kind == K_MISS) ? cmo.miss_ready_i : cmo.dir_inv_ready_i) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_in_rsp = 1'b1;
      end
    end else if (!m_ready) begin
      m_ready = 1'b1;
    end else if (cmo.req_valid_i) begin
      m_ready = 1'b0;
      m_need  = cmo.req_need_rsp_i;
      m_sid   = cmo.req_sid_i;
      m_tid   = cmo.req_tid_i;
      m_err   = (cmo.req_op_i == 2'd3);
      it      = '0;
      case (cmo.req_op_i)
        2'd0: begin it.kind = K_LINE; it.nline = cmo.req_nline_i; m_q.push_back(it); end
        2'd1: begin
          for (int s = 0; s < int'(NSETS); s++) begin
            it.kind = K_ALL;
            it.set  = SET_W'(s);
            m_q.push_back(it);
          end
        end
`ifdef HPDCACHE_CMO_PREFETCH_EN
        2'd2: begin it.kind = K_MISS; it.nline = cmo.req_nline_i; m_q.push_back(it); end
`endif
        default: ;
      endcase
      if (m_q.size() == 0) m_in_rsp = 1'b1;
    end
  endfunction

  // Observation log used by the directed scenarios.
  int set_log[$];
  int rsp_cnt    = 0;
  int rsp_at_log = 0;

  always @(negedge clk_i) begin : compare
    item_t h;
    bit    have;
    bit    rv;
    if (!rst_ni) model_reset();
    have = (m_q.size() > 0);
    h    = have ? m_q[0] : '0;
    rv   = m_in_rsp && m_need;
    check("req_ready",  64'(cmo.req_ready_o),     64'(m_ready));
    check("dir_valid",  64'(cmo.dir_inv_valid_o), 64'(have && h.kind != K_MISS));
    check("dir_all",    64'(cmo.dir_inv_all_o),   64'(have && h.kind == K_ALL));
    check("dir_set",    64'(cmo.dir_inv_set_o),   (have && h.kind == K_ALL) ? 64'(h.set) : 64'd0);
    check("dir_nline",  64'(cmo.dir_inv_nline_o), (have && h.kind == K_LINE) ? 64'(h.nline) : 64'd0);
    check("miss_valid", 64'(cmo.miss_valid_o),    64'(have && h.kind == K_MISS));
    check("miss_nline", 64'(cmo.miss_nline_o),    (have && h.kind == K_MISS) ? 64'(h.nline) : 64'd0);
    check("rsp_valid",  64'(cmo.rsp_valid_o),     64'(rv));
    check("rsp_sid",    64'(cmo.rsp_sid_o),       rv ? 64'(m_sid) : 64'd0);
    check("rsp_tid",    64'(cmo.rsp_tid_o),       rv ? 64'(m_tid) : 64'd0);
    check("rsp_error",  64'(cmo.rsp_error_o),     64'(rv && m_err));
    check("busy",       64'(cmo.busy_o),          64'(have || m_in_rsp));
    if (rst_ni) begin
      if (cmo.dir_inv_valid_o && cmo.dir_inv_all_o && cmo.dir_inv_ready_i)
        set_log.push_back(int'(cmo.dir_inv_set_o));
      if (cmo.rsp_valid_o) begin
        rsp_cnt++;
        rsp_at_log = set_log.size();
      end
      model_step();
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request and hold it until accepted; returns one cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [NLINE_W-1:0] nl,
                      input logic [SID_W-1:0] sid, input logic [TID_W-1:0] tid,
                      input logic need);
    bit acc;
    acc = 1'b0;
    cmo.req_valid_i    = 1'b1;
    cmo.req_op_i       = op;
    cmo.req_nline_i    = nl;
    cmo.req_sid_i      = sid;
    cmo.req_tid_i      = tid;
    cmo.req_need_rsp_i = need;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk_i);
      acc = cmo.req_ready_o;
      cycle();
    end
    cmo.req_valid_i = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    cmo.req_valid_i     = 1'b0;
    cmo.dir_inv_ready_i = 1'b1;
    cmo.miss_ready_i    = 1'b1;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk_i);
      idle = cmo.req_ready_o && !cmo.busy_o;
      cycle();
    end
    if (!idle) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] r;
    logic [63:0] w;
    int          rsp0;
    int          order_err;
    bit          found;

    rst_ni              = 1'b1;
    cmo.req_valid_i     = 1'b0;
    cmo.req_op_i        = '0;
    cmo.req_nline_i     = '0;
    cmo.req_sid_i       = '0;
    cmo.req_tid_i       = '0;
    cmo.req_need_rsp_i  = 1'b0;
    cmo.dir_inv_ready_i = 1'b0;
    cmo.miss_ready_i    = 1'b0;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Ready stays low until the first clock after reset release.
    @(negedge clk_i);
    check("ready_low_after_release", 64'(cmo.req_ready_o), 64'd0);
    check("busy_low_after_release",  64'(cmo.busy_o),      64'd0);
    cycle();
    @(negedge clk_i);
    check("ready_high_next_cycle",   64'(cmo.req_ready_o), 64'd1);
    cycle();

    // INVAL_NLINE with the directory always ready.
    cmo.dir_inv_ready_i = 1'b1;
    send(2'd0, 34'h123, 3'd2, 6'd5, 1'b1);
    @(negedge clk_i);
    check("op0_dir_valid", 64'(cmo.dir_inv_valid_o), 64'd1);
    check("op0_dir_nline", 64'(cmo.dir_inv_nline_o), 64'h123);
    check("op0_dir_all",   64'(cmo.dir_inv_all_o),   64'd0);
    check("op0_rsp_early", 64'(cmo.rsp_valid_o),     64'd0);
    cycle();
    @(negedge clk_i);
    check("op0_dir_one_cycle", 64'(cmo.dir_inv_valid_o), 64'd0);
    check("op0_rsp_valid",     64'(cmo.rsp_valid_o),     64'd1);
    check("op0_rsp_tid",       64'(cmo.rsp_tid_o),       64'd5);
    check("op0_rsp_sid",       64'(cmo.rsp_sid_o),       64'd2);
    cycle();
    @(negedge clk_i);
    check("op0_rsp_single", 64'(cmo.rsp_valid_o), 64'd0);
    check("op0_ready_back", 64'(cmo.req_ready_o), 64'd1);
    cycle();

    // INVAL_ALL with the directory ready every other cycle.
    cmo.dir_inv_ready_i = 1'b0;
    set_log.delete();
    rsp0 = rsp_cnt;
    send(2'd1, 34'h0, 3'd1, 6'd9, 1'b1);
    for (int i = 0; i < 400 && rsp_cnt == rsp0; i++) begin
      cmo.dir_inv_ready_i = ~cmo.dir_inv_ready_i;
      cycle();
    end
    repeat (3) cycle();
    order_err = 0;
    foreach (set_log[i]) if (set_log[i] != i) order_err++;
    check("op1_set_count",   64'(set_log.size()), 64'd64);
    check("op1_set_order",   64'(order_err),      64'd0);
    check("op1_rsp_count",   64'(rsp_cnt - rsp0), 64'd1);
    check("op1_rsp_after63", 64'(rsp_at_log),     64'd64);

    // PREFETCH with the miss handler stalled.
    cmo.dir_inv_ready_i = 1'b1;
    cmo.miss_ready_i    = 1'b0;
    send(2'd2, 34'h2_ABCD_EF01, 3'd3, 6'd17, 1'b1);
`ifdef HPDCACHE_CMO_PREFETCH_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("op2_miss_valid_stall", 64'(cmo.miss_valid_o), 64'd1);
      check("op2_miss_nline_stall", 64'(cmo.miss_nline_o), 64'h2_ABCD_EF01);
      check("op2_ready_low",        64'(cmo.req_ready_o),  64'd0);
      cycle();
    end
    cmo.miss_ready_i = 1'b1;
    cycle();
    @(negedge clk_i);
    check("op2_rsp_valid", 64'(cmo.rsp_valid_o), 64'd1);
    check("op2_rsp_error", 64'(cmo.rsp_error_o), 64'd0);
`else
    @(negedge clk_i);
    check("op2_no_miss",   64'(cmo.miss_valid_o), 64'd0);
    check("op2_rsp_valid", 64'(cmo.rsp_valid_o),  64'd1);
    check("op2_rsp_error", 64'(cmo.rsp_error_o),  64'd0);
    check("op2_rsp_tid",   64'(cmo.rsp_tid_o),    64'd17);
`endif
    cycle();
    cmo.miss_ready_i = 1'b0;

    // Reserved op returns an error one cycle after acceptance.
    send(2'd3, 34'h0, 3'd4, 6'd33, 1'b1);
    @(negedge clk_i);
    check("op3_rsp_valid", 64'(cmo.rsp_valid_o), 64'd1);
    check("op3_rsp_error", 64'(cmo.rsp_error_o), 64'd1);
    check("op3_rsp_tid",   64'(cmo.rsp_tid_o),   64'd33);
    cycle();

    // INVAL_NLINE without a response request.
    send(2'd0, 34'h3_0000_0042, 3'd0, 6'd1, 1'b0);
    @(negedge clk_i);
    check("op0n_dir_valid", 64'(cmo.dir_inv_valid_o), 64'd1);
    cycle();
    @(negedge clk_i);
    check("op0n_no_rsp",   64'(cmo.rsp_valid_o), 64'd0);
    check("op0n_busy_rsp", 64'(cmo.busy_o),      64'd1);
    cycle();
    @(negedge clk_i);
    check("op0n_busy_fall", 64'(cmo.busy_o),      64'd0);
    check("op0n_ready",     64'(cmo.req_ready_o), 64'd1);
    cycle();

    // Reset in the middle of INVAL_ALL, then restart.
    send(2'd1, 34'h0, 3'd5, 6'd40, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_i);
      found = (cmo.dir_inv_set_o == SET_W'(20));
      if (!found) cycle();
    end
    if (!found) check("set20_timeout", 64'd0, 64'd1);
    rsp0 = rsp_cnt;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_dir_valid", 64'(cmo.dir_inv_valid_o), 64'd0);
    check("rst_dir_all",   64'(cmo.dir_inv_all_o),   64'd0);
    check("rst_dir_set",   64'(cmo.dir_inv_set_o),   64'd0);
    check("rst_busy",      64'(cmo.busy_o),          64'd0);
    check("rst_ready",     64'(cmo.req_ready_o),     64'd0);
    cycle();
    cycle();
    rst_ni = 1'b1;
    repeat (3) cycle();
    check("rst_no_rsp", 64'(rsp_cnt - rsp0), 64'd0);
    set_log.delete();
    send(2'd1, 34'h0, 3'd6, 6'd41, 1'b1);
    @(negedge clk_i);
    check("restart_set0",  64'(cmo.dir_inv_set_o),   64'd0);
    check("restart_valid", 64'(cmo.dir_inv_valid_o), 64'd1);
    cycle();
    for (int i = 0; i < 200 && rsp_cnt == rsp0; i++) cycle();
    check("restart_set_count", 64'(set_log.size()), 64'd64);
    check("restart_rsp",       64'(rsp_cnt - rsp0), 64'd1);
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      r = $urandom;
      w = {$urandom, $urandom};
      cmo.req_valid_i = r[0];
      case (r[3:1])
        3'd0, 3'd1, 3'd2: cmo.req_op_i = 2'd0;
        3'd3:             cmo.req_op_i = 2'd1;
        3'd4, 3'd5:       cmo.req_op_i = 2'd2;
        default:          cmo.req_op_i = 2'd3;
      endcase
      cmo.req_need_rsp_i  = r[4];
      cmo.req_sid_i       = r[7:5];
      cmo.req_tid_i       = r[13:8];
      cmo.req_nline_i     = w[NLINE_W-1:0];
      cmo.dir_inv_ready_i = 1'($urandom_range(0, 1));
      cmo.miss_ready_i    = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
